conv_enc_frame: RTL

//   Parametrised rate-1/N feed-forward convolutional encoder with frame support.

---
 rtl/conv_enc_frame.sv | 116 +++++++++++
 1 files changed

// File: rtl/conv_enc_frame.sv
// Rate-1/N feed-forward convolutional encoder with optional zero-tail
// frame termination and a single registered output slot.
module conv_enc_frame #(
  parameter int K = 3,
  parameter int N = 2,
  parameter logic [N*K-1:0] G = {3'b101, 3'b111},
  parameter bit TAIL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int CW = $clog2(K);

  typedef enum logic {
    DATA,
    TAIL
  } state_t;

  state_t        state, state_nx;
  logic [K-2:0]  sr, sr_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          slot_free;
  logic          take;
  logic          emit;
  logic          last_sym;
  logic          x;
  logic [K-1:0]  v;
  logic [K-1:0]  vs;
  logic [N-1:0]  sym;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DATA;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sr    <= sr_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    slot_free = !out_valid || out_ready;
    in_ready  = (state == DATA) && slot_free;
    busy      = (state == TAIL);
    take      = in_ready && in_valid;
    emit      = take || (busy && slot_free);
    x         = take ? in_bit : 1'b0;
    v         = {x, sr};
    // low K-1 bits of v>>1 are {x, sr[K-2:1]}, valid for K=2 too
    vs        = v >> 1;
    sym       = '0;
    for (int j = 0; j < N; j++) begin
      sym[j] = ^(v & G[j*K +: K]);
    end
    state_nx  = state;
    sr_nx     = sr;
    cnt_nx    = cnt;
    last_sym  = 1'b0;
    unique case (state)
      DATA: begin
        if (take) begin
          sr_nx = vs[K-2:0];
          if (in_last) begin
            if (TAIL_EN) begin
              state_nx = TAIL;
              cnt_nx   = CW'(K - 1);
            end else begin
              last_sym = 1'b1;
              sr_nx    = '0;
            end
          end
        end
      end
      TAIL: begin
        if (slot_free) begin
          sr_nx  = vs[K-2:0];
          cnt_nx = cnt - 1'b1;
          if (cnt == CW'(1)) begin
            last_sym = 1'b1;
            state_nx = DATA;
          end
        end
      end
      default: begin
        state_nx = DATA;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= sym;
      out_last  <= last_sym;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
